// File: rtl/pixel_buffer_scanner.sv
// Pixel framebuffer on the plot interface: accepts plot writes, bulk-clears to a
// fixed colour, and streams the contents back in raster order on request.
module pixel_buffer_scanner #(
   parameter int WIDTH_PX  = 160,
   parameter int HEIGHT_PX = 120,
   parameter int COLOUR_W  = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [7:0]          x,
   input  logic [6:0]          y,
   input  logic [COLOUR_W-1:0] colour,
   input  logic                plot,
   input  logic                clear,
   input  logic [COLOUR_W-1:0] clear_colour,
   input  logic                scan_start,
   output logic                busy,
   output logic [7:0]          scan_x,
   output logic [6:0]          scan_y,
   output logic [COLOUR_W-1:0] scan_colour,
   output logic                scan_valid,
   output logic                scan_done,
   output logic                dropped
);

   localparam int         NPIX   = WIDTH_PX * HEIGHT_PX;
   localparam int         AW     = $clog2(NPIX);
   localparam logic [7:0] X_LIM  = 8'(WIDTH_PX);
   localparam logic [7:0] X_LAST = 8'(WIDTH_PX - 1);
   localparam logic [6:0] Y_LIM  = 7'(HEIGHT_PX);
   localparam logic [6:0] Y_LAST = 7'(HEIGHT_PX - 1);
   localparam logic [AW-1:0] A_LAST = AW'(NPIX - 1);

   typedef enum logic { W_IDLE, W_CLEAR } wstate_t;
   typedef enum logic [1:0] { S_IDLE, S_SCAN, S_DRAIN } sstate_t;

   // ---------------- storage: one write port, one registered read port
   logic [COLOUR_W-1:0] mem [0:NPIX-1];
   logic                we;
   logic [AW-1:0]       waddr;
   logic [COLOUR_W-1:0] wdata;
   logic                rd_en;
   logic [AW-1:0]       raddr;
   logic [COLOUR_W-1:0] rd_q;

   // Both updates are non-blocking, so a same-address read sees the old word.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (rd_en)
         rd_q <= mem[raddr];
   end

   // ---------------- write side
   wstate_t             w_state, w_next;
   logic [AW-1:0]       clr_addr;
   logic [COLOUR_W-1:0] clr_col;
   logic [AW-1:0]       plot_addr;
   logic                in_range;
   logic                drop_evt;

   assign plot_addr = AW'(y) * AW'(WIDTH_PX) + AW'(x);
   assign in_range  = (x < X_LIM) && (y < Y_LIM);
   assign busy      = (w_state == W_CLEAR);

   always_comb begin
      w_next   = w_state;
      we       = 1'b0;
      waddr    = plot_addr;
      wdata    = colour;
      drop_evt = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (clear) begin
               w_next   = W_CLEAR;
               drop_evt = plot;
            end else if (plot) begin
               if (in_range)
                  we = 1'b1;
               else
                  drop_evt = 1'b1;
            end
         end
         W_CLEAR: begin
            we       = 1'b1;
            waddr    = clr_addr;
            wdata    = clr_col;
            drop_evt = plot;
            if (clr_addr == A_LAST)
               w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_state  <= W_IDLE;
         clr_addr <= '0;
         clr_col  <= '0;
         dropped  <= 1'b0;
      end else begin
         w_state <= w_next;
         if (w_state == W_IDLE) begin
            clr_addr <= '0;
            if (clear)
               clr_col <= clear_colour;
         end else begin
            clr_addr <= clr_addr + 1'b1;
         end
         if (drop_evt)
            dropped <= 1'b1;
      end
   end

   // ---------------- scan side
   sstate_t       s_state, s_next;
   logic [7:0]    sx;
   logic [6:0]    sy;
   logic [AW-1:0] saddr;
   logic          s_last;
   logic          valid_q;

   assign s_last = (sx == X_LAST) && (sy == Y_LAST);
   assign rd_en  = (s_state == S_SCAN);
   assign raddr  = saddr;

   always_comb begin
      s_next = s_state;
      case (s_state)
         S_IDLE:  if (scan_start) s_next = S_SCAN;
         S_SCAN:  if (s_last)     s_next = S_DRAIN;
         S_DRAIN: s_next = S_IDLE;
         default: s_next = S_IDLE;
      endcase
   end

   // Counters hold on the final pixel so the read address never leaves the array.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_state <= S_IDLE;
         sx      <= '0;
         sy      <= '0;
         saddr   <= '0;
      end else begin
         s_state <= s_next;
         if (s_state == S_SCAN) begin
            if (!s_last) begin
               saddr <= saddr + 1'b1;
               if (sx == X_LAST) begin
                  sx <= '0;
                  sy <= sy + 1'b1;
               end else begin
                  sx <= sx + 1'b1;
               end
            end
         end else begin
            sx    <= '0;
            sy    <= '0;
            saddr <= '0;
         end
      end
   end

   // Coordinates are delayed one cycle to line up with the registered read data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q   <= 1'b0;
         scan_done <= 1'b0;
         scan_x    <= '0;
         scan_y    <= '0;
      end else begin
         valid_q   <= (s_state == S_SCAN);
         scan_done <= (s_state == S_DRAIN);
         scan_x    <= sx;
         scan_y    <= sy;
      end
   end

   assign scan_valid  = valid_q;
   assign scan_colour = valid_q ? rd_q : '0;

endmodule
